// File: rtl/regbank_pkg.sv
// Shared types for the register bank write arbiter: entry type, init value, controller states.
package regbank_pkg;

    typedef logic [7:0] entry_t;

    localparam entry_t ENTRY_INIT = '0;

    typedef enum logic {ST_INIT, ST_RUN} ctrl_state_t;

endpackage

// File: rtl/regbank_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the requester just after rr_last has top priority.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int RW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            enable,
    input  logic [NREQ-1:0] req,
    input  logic [RW-1:0]   rr_last,
    output logic [NREQ-1:0] gnt
);

    logic          found;
    logic [RW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        // Scan rr_last+1 .. rr_last+NREQ; the first asserted request wins.
        for (int k = 1; k <= NREQ; k++) begin
            idx = RW'((int'(rr_last) + k) % NREQ);
            if (enable && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Register bank with a single round-robin-shared write port and an init sweep
// that runs after reset and on every reinit pulse.
module regbank_write_arbiter
    import regbank_pkg::*;
#(
    parameter int     NREQ       = 4,
    parameter int     DEPTH      = 8,
    parameter int     AW         = 3,
    parameter entry_t INIT_VALUE = regbank_pkg::ENTRY_INIT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      reinit,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*AW-1:0]        wr_addr,
    input  logic [NREQ*$bits(entry_t)-1:0] wr_data,
    output logic [NREQ-1:0]           gnt,
    output logic                      init_done,
    input  logic [AW-1:0]             rd_addr,
    output logic [$bits(entry_t)-1:0] rd_data
);

    localparam int EW = $bits(entry_t);
    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ctrl_state_t   state, state_nxt;
    logic [AW-1:0] init_ptr, init_ptr_nxt;
    logic [RW-1:0] rr_last, gidx;

    logic          we;
    logic [AW-1:0] waddr;
    entry_t        wdata;
    logic [IW-1:0] widx, ridx;
    logic          w_in_range, r_in_range;

    entry_t        mem [DEPTH];

    assign init_done = (state == ST_RUN);

    rr_arbiter #(
        .NREQ (NREQ),
        .RW   (RW)
    ) u_arb (
        .enable  (state == ST_RUN),
        .req     (req),
        .rr_last (rr_last),
        .gnt     (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_ptr <= '0;
        end else begin
            state    <= state_nxt;
            init_ptr <= init_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_ptr_nxt = init_ptr;
        case (state)
            ST_INIT: begin
                // reinit beats the final sweep write and restarts from entry 0.
                if (reinit) begin
                    init_ptr_nxt = '0;
                end else if (int'(init_ptr) == DEPTH - 1) begin
                    state_nxt    = ST_RUN;
                    init_ptr_nxt = '0;
                end else begin
                    init_ptr_nxt = init_ptr + 1'b1;
                end
            end
            ST_RUN: begin
                if (reinit) begin
                    state_nxt    = ST_INIT;
                    init_ptr_nxt = '0;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // Single write port: the sweep owns it in ST_INIT, the granted requester in ST_RUN.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = INIT_VALUE;
        gidx  = rr_last;
        if (state == ST_INIT) begin
            we    = 1'b1;
            waddr = init_ptr;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) begin
                    we    = 1'b1;
                    gidx  = RW'(i);
                    waddr = wr_addr[i*AW +: AW];
                    wdata = wr_data[i*EW +: EW];
                end
            end
        end
    end

    assign w_in_range = int'(waddr) < DEPTH;
    assign r_in_range = int'(rd_addr) < DEPTH;
    assign widx       = waddr[IW-1:0];
    assign ridx       = rd_addr[IW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= RW'(NREQ - 1);
        end else if (|gnt) begin
            rr_last <= gidx;
        end
    end

    // Out-of-range grants are consumed but must not alias onto a real entry.
    always_ff @(posedge clk) begin
        if (we && w_in_range) begin
            mem[widx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= r_in_range ? mem[ridx] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert ($onehot0(gnt));
            assert (init_done || (gnt == '0));
            assert ((gnt & ~req) == '0);
        end
    end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Scoreboard bench for regbank_write_arbiter (NREQ=4, DEPTH=8, AW=4).
module tb_regbank_write_arbiter;
    import regbank_pkg::*;

    localparam int NREQ  = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 4;
    localparam int EW    = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 reinit;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   wr_addr;
    logic [NREQ*EW-1:0]   wr_data;
    logic [NREQ-1:0]      gnt;
    logic                 init_done;
    logic [AW-1:0]        rd_addr;
    logic [EW-1:0]        rd_data;

    int       n_cmp = 0;
    int       n_err = 0;
    int       exp_q[$];
    logic [7:0] model_mem [16];

    regbank_write_arbiter #(
        .NREQ       (NREQ),
        .DEPTH      (DEPTH),
        .AW         (AW),
        .INIT_VALUE (ENTRY_INIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reinit    (reinit),
        .req       (req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .gnt       (gnt),
        .init_done (init_done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int i, input int a, input int d);
        wr_addr[i*AW +: AW] = AW'(a);
        wr_data[i*EW +: EW] = EW'(d);
    endtask

    function automatic int exp_rd(input int a);
        return (a < DEPTH) ? int'(model_mem[a]) : 0;
    endfunction

    task automatic model_sweep();
        for (int a = 0; a < 16; a++) model_mem[a] = 8'h00;
    endtask

    task automatic test_reset();
        int e;
        rst_n = 1'b0; reinit = 1'b0; req = '0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        tick(); tick();
        n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        rst_n = 1'b1;
        repeat (DEPTH - 1) tick();
        n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL sweep_early: got %b want 0 after 7 cycles", init_done); end
        tick();
        n_cmp++; if (init_done !== 1'b1) begin n_err++; $display("FAIL sweep_done: got %b want 1 after 8 cycles", init_done); end
        model_sweep();
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            exp_q.push_back(exp_rd(a));
            tick();
            e = exp_q.pop_front();
            n_cmp++; if (rd_data !== EW'(e)) begin n_err++; $display("FAIL init_read[%0d]: got %h want %h", a, rd_data, e); end
        end
    endtask

    task automatic test_round_robin();
        int seq[5] = '{0, 1, 2, 3, 0};
        int e;
        for (int i = 0; i < NREQ; i++) set_wr(i, i, 8'h10 + i);
        req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            exp_q.push_back(1 << seq[c]);
            #1;
            e = exp_q.pop_front();
            n_cmp++; if (gnt !== NREQ'(e)) begin n_err++; $display("FAIL rr_gnt[%0d]: got %b want %b", c, gnt, NREQ'(e)); end
            model_mem[seq[c]] = 8'(8'h10 + seq[c]);
            tick();
        end
        req = '0;
        for (int a = 0; a < NREQ; a++) begin
            rd_addr = AW'(a);
            exp_q.push_back(exp_rd(a));
            tick();
            e = exp_q.pop_front();
            n_cmp++; if (rd_data !== EW'(e)) begin n_err++; $display("FAIL rr_read[%0d]: got %h want %h", a, rd_data, e); end
        end
    endtask

    task automatic test_single();
        int e;
        req = 4'b0100;
        set_wr(2, 5, 8'hA5);
        rd_addr = AW'(5);
        #1;
        n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt: got %b want 0100", gnt); end
        exp_q.push_back(exp_rd(5));
        tick();
        e = exp_q.pop_front();
        n_cmp++; if (rd_data !== EW'(e)) begin n_err++; $display("FAIL single_rdw_old: got %h want %h", rd_data, e); end
        model_mem[5] = 8'hA5;
        req = '0;
        exp_q.push_back(exp_rd(5));
        tick();
        e = exp_q.pop_front();
        n_cmp++; if (rd_data !== EW'(e)) begin n_err++; $display("FAIL single_read: got %h want %h", rd_data, e); end
    endtask

    task automatic test_reinit();
        int e;
        set_wr(0, 1, 8'h3C);
        req = 4'b0001;
        reinit = 1'b1;
        #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL reinit_gnt: got %b want 0001", gnt); end
        tick();
        reinit = 1'b0;
        model_mem[1] = 8'h3C;
        rd_addr = AW'(1);
        exp_q.push_back(exp_rd(1));
        for (int c = 0; c < DEPTH; c++) begin
            n_cmp++; if (gnt !== 4'b0000 || init_done !== 1'b0) begin
                n_err++; $display("FAIL reinit_sweep[%0d]: gnt %b init_done %b want 0000/0", c, gnt, init_done);
            end
            if (c == DEPTH - 1) req = '0;
            tick();
            if (c == 0) begin
                e = exp_q.pop_front();
                n_cmp++; if (rd_data !== EW'(e)) begin n_err++; $display("FAIL reinit_commit: got %h want %h", rd_data, e); end
            end
        end
        n_cmp++; if (init_done !== 1'b1) begin n_err++; $display("FAIL reinit_done: got %b want 1", init_done); end
        model_sweep();
        exp_q.push_back(exp_rd(1));
        tick();
        e = exp_q.pop_front();
        n_cmp++; if (rd_data !== EW'(e)) begin n_err++; $display("FAIL reinit_cleared: got %h want %h", rd_data, e); end
    endtask

    task automatic test_addr_range();
        int e;
        int addrs[3] = '{7, 9, 1};
        req = 4'b0010;
        set_wr(1, 7, 8'h77);
        #1;
        n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL range_gnt7: got %b want 0010", gnt); end
        model_mem[7] = 8'h77;
        tick();
        set_wr(1, 9, 8'h99);
        #1;
        n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL range_gnt9: got %b want 0010", gnt); end
        tick();
        req = '0;
        for (int k = 0; k < 3; k++) begin
            rd_addr = AW'(addrs[k]);
            exp_q.push_back(exp_rd(addrs[k]));
            tick();
            e = exp_q.pop_front();
            n_cmp++; if (rd_data !== EW'(e)) begin n_err++; $display("FAIL range_read[%0d]: got %h want %h", addrs[k], rd_data, e); end
        end
    endtask

    task automatic test_reset_mid();
        int e;
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        req = 4'b1111;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (gnt !== 4'b0000 || init_done !== 1'b0) begin
            n_err++; $display("FAIL midreset_outputs: gnt %b init_done %b want 0000/0", gnt, init_done);
        end
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL midreset_rd_data: got %h want 00", rd_data); end
        tick();
        rst_n = 1'b1;
        repeat (DEPTH - 1) tick();
        n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL midreset_early: got %b want 0", init_done); end
        // reinit coinciding with the last sweep write restarts the sweep
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL last_write_reinit: got %b want 0", init_done); end
        repeat (DEPTH - 1) tick();
        n_cmp++; if (init_done !== 1'b0 || gnt !== 4'b0000) begin
            n_err++; $display("FAIL restart_early: init_done %b gnt %b want 0/0000", init_done, gnt);
        end
        tick();
        n_cmp++; if (init_done !== 1'b1) begin n_err++; $display("FAIL restart_done: got %b want 1", init_done); end
        exp_q.push_back(4'b0001);
        e = exp_q.pop_front();
        n_cmp++; if (gnt !== NREQ'(e)) begin n_err++; $display("FAIL rr_after_reset: got %b want %b", gnt, NREQ'(e)); end
        req = '0;
        model_sweep();
        rd_addr = AW'(7);
        exp_q.push_back(exp_rd(7));
        tick();
        e = exp_q.pop_front();
        n_cmp++; if (rd_data !== EW'(e)) begin n_err++; $display("FAIL midreset_read7: got %h want %h", rd_data, e); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_reinit();
        test_addr_range();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
